// File: rtl/cnn_window_gen.sv
// Sliding KX x KY window generator for a raster pixel stream, feeding the CNN MAC stage.
// KY-1 line buffers plus a register window; one registered window per valid stride-1 position.
module cnn_window_gen #(
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int IX     = 28,
    parameter int IY     = 28
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_soft_reset,
    input  logic                        i_in_valid,
    input  logic [I_F_BW-1:0]           i_in_pixel,
    output logic                        o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]     o_ot_fmap,
    output logic                        o_frame_done
);

    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;
    localparam int FW = KX * KY * I_F_BW;
    localparam logic [CW-1:0] COL_LAST  = CW'(IX - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IY - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KY - 1);

    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [I_F_BW-1:0] lb_r      [KY-1][IX];
    logic [I_F_BW-1:0] win_r     [KY][KX];
    logic [I_F_BW-1:0] win_nxt_s [KY][KX];
    logic [I_F_BW-1:0] new_col_s [KY];
    logic [FW-1:0]     nxt_fmap_s;
    logic              accept_s;
    logic              win_ok_s;
    logic              col_last_s;
    logic              row_last_s;

    // Accept qualification and window-position gating from the raster counters
    always_comb begin
        accept_s   = i_in_valid & ~i_soft_reset;
        col_last_s = (col_r == COL_LAST);
        row_last_s = (row_r == ROW_LAST);
        win_ok_s   = (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
    end

    // New column is the buffered lines at this column with the live pixel at the bottom
    for (genvar gy = 0; gy < KY; gy++) begin : g_row
        if (gy < KY - 1) begin : g_lb
            assign new_col_s[gy] = lb_r[gy][col_r];
        end else begin : g_px
            assign new_col_s[gy] = i_in_pixel;
        end
        for (genvar gx = 0; gx < KX; gx++) begin : g_col
            if (gx < KX - 1) begin : g_shift
                assign win_nxt_s[gy][gx] = win_r[gy][gx+1];
            end else begin : g_new
                assign win_nxt_s[gy][gx] = new_col_s[gy];
            end
            assign nxt_fmap_s[(gy*KX+gx)*I_F_BW +: I_F_BW] = win_nxt_s[gy][gx];
        end
    end

    // Line buffers and window registers: storage only, untouched by either reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int ky = 0; ky < KY - 1; ky++) begin
                lb_r[ky][col_r] <= new_col_s[ky+1];
            end
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win_r[ky][kx] <= win_nxt_s[ky][kx];
                end
            end
        end
    end

    // Raster counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_r        <= '0;
            row_r        <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_frame_done <= 1'b0;
        end else if (i_soft_reset) begin
            col_r        <= '0;
            row_r        <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_frame_done <= 1'b0;
        end else if (i_in_valid) begin
            if (col_last_s) begin
                col_r <= '0;
                row_r <= row_last_s ? '0 : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
            o_ot_valid   <= win_ok_s;
            o_frame_done <= win_ok_s & col_last_s & row_last_s;
            if (win_ok_s) begin
                o_ot_fmap <= nxt_fmap_s;
            end
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
        end
    end

endmodule
